vscpu_gen2: RTL and testbench
=============================

VSCPU_GEN2 -- requirements
Module: vscpu_gen2

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data/instruction word width; DW >= 4+2*AW.
REQ-002 SHALL have parameter AW, default 14, meaning word address width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded at reset.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_req  out  1  memory access request.
REQ-007 SHALL have port mem_we  out  1  write enable qualifying mem_req.
REQ-008 SHALL have port mem_addr  out  AW  word address.
REQ-009 SHALL have port mem_wdata  out  DW  write data.
REQ-010 SHALL have port mem_rdata  in  DW  read data, valid when mem_ack=1.
REQ-011 SHALL have port mem_ack  in  1  access completes on a clk edge where mem_req=1 and mem_ack=1.
REQ-012 SHALL have port halted  out  1  high while in HALT.
REQ-013 SHALL have port illegal  out  1  one-cycle pulse when an illegal opcode retires.

Function
REQ-014 SHALL decode IW: op=IW[DW-1:DW-3], im=IW[DW-4], A=IW[2AW-1:AW], B=IW[AW-1:0]; imm=B zero-extended to DW.
REQ-015 SHALL execute, opcode 0-7, im=0 / im=1: ADD M[A]+=M[B] / M[A]+=imm; NAND M[A]=~(M[A]&X); SRL M[A]=M[A]>>X (X>=DW gives 0); LT M[A]=(M[A]<X) unsigned ?1:0; CP M[A]=M[B] / M[A]=imm; MUL M[A]=low DW bits of M[A]*X; BZJ PC=(M[B]==0)?A:PC+1 / PC=M[A]+imm unconditional; CPI M[M[A]]=M[B] / M[M[A]]=imm. X=M[B] or imm.
REQ-016 SHALL use states FETCH, RD_B, RD_A, WR, HALT; each state performing an access holds it until ack, then advances.
REQ-017 SHALL order accesses FETCH -> RD_B (im=0 or BZJ im=0) -> RD_A (ALU ops, CPI, BZJi) -> WR (all except BZJ) -> FETCH; unneeded states skipped.
REQ-018 SHALL hold mem_addr, mem_we, mem_wdata stable while mem_req=1 and ack is low; at most one outstanding access; mem_req=0 in HALT.
REQ-019 SHALL, with mem_ack tied high, take ADD/NAND/SRL/LT/MUL/CPI 4 cycles, immediate forms and CP 3, CPi 2, BZJ and BZJi 2.
REQ-020 SHALL use mem_rdata[AW-1:0] as the CPI write address and as the BZJi base; PC and all addresses wrap modulo 2^AW.
REQ-021 SHALL increment PC by 1 at the end of WR for every non-branch instruction.
REQ-022 SHALL enter HALT when a taken branch targets the current PC; HALT is left only by reset.

Reset
REQ-023 SHALL, on a clk edge with rst=1, set PC=RESET_PC, state=FETCH, IW=0, operand register=0, halted=0, illegal=0, abandoning any in-flight access.
REQ-024 SHALL drive mem_req=0 and mem_we=0 combinationally while rst=1.

Configuration
REQ-025 SHALL compile MUL/MULi in when VSCPU_GEN2_MUL_EN is defined.
REQ-026 SHALL, without VSCPU_GEN2_MUL_EN, treat opcode 5 as illegal: no RD_A/WR, PC+1, illegal pulse on retirement (2 cycles with ack tied high).

Structure
REQ-027 SHALL place opcode constants, the state enum and field-index helpers in shared package vscpu_pkg.
REQ-028 SHALL implement result computation in combinational sub-module vscpu_alu (op, a, x -> result).

Verification
REQ-029 SHALL cover, with ack high: M[10]=5, M[11]=7, ADD A=10 B=11 -> M[10]=12 after 4 cycles; PC+1.
REQ-030 SHALL cover random ack stalls of 0-5 cycles on every access -> identical final memory, and addr/we/wdata stable during each stall.
REQ-031 SHALL cover M[20]=30, M[21]=0xAB, CPI A=20 B=21 -> M[30]=0xAB; CPIi A=20 imm=3 -> M[30]=3.
REQ-032 SHALL cover M[5]=0, BZJ at PC=8 with A=8 B=5 -> halted=1 and mem_req=0 thereafter; BZJ with M[5]=1 -> PC=9.
REQ-033 SHALL cover rst asserted mid-WR with ack low -> no write completes; next request is fetch at RESET_PC.
REQ-034 SHALL cover MULi M[A]=6 imm=7 -> 42 with the macro; without it -> M[A] unchanged, illegal pulse, PC+1.

Source files
------------

// File: rtl/vscpu_pkg.sv
// Shared definitions for the vscpu_gen2 core: opcodes, FSM states and instruction field positions.
// Optional MUL/MULi support is controlled by the VSCPU_GEN2_MUL_EN macro.
package vscpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NAND = 3'd1,
        OP_SRL  = 3'd2,
        OP_LT   = 3'd3,
        OP_CP   = 3'd4,
        OP_MUL  = 3'd5,
        OP_BZJ  = 3'd6,
        OP_CPI  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_RD_B,
        ST_RD_A,
        ST_WR,
        ST_HALT
    } state_e;

`ifdef VSCPU_GEN2_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // Word layout: op in the top three bits, im just below, A above B at the bottom.
    function automatic int op_lsb(input int dw);
        return dw - 3;
    endfunction

    function automatic int im_pos(input int dw);
        return dw - 4;
    endfunction

    function automatic logic op_is_illegal(input opcode_e op);
        return (op == OP_MUL) && !MUL_EN;
    endfunction

endpackage

// File: rtl/vscpu_alu.sv
// Combinational result unit for the read-modify-write instructions of vscpu_gen2.
// MUL is only built when VSCPU_GEN2_MUL_EN is defined.
module vscpu_alu
    import vscpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  opcode_e       op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] x_i,
    output logic [DW-1:0] result_o
);

    localparam logic [DW-1:0] DW_LIMIT = DW'(DW);

    always_comb begin
        result_o = x_i;
        case (op_i)
            OP_ADD:  result_o = a_i + x_i;
            OP_NAND: result_o = ~(a_i & x_i);
            OP_SRL:  result_o = (x_i >= DW_LIMIT) ? '0 : (a_i >> x_i);
            OP_LT:   result_o = {{(DW-1){1'b0}}, (a_i < x_i)};
`ifdef VSCPU_GEN2_MUL_EN
            OP_MUL:  result_o = a_i * x_i;
`endif
            default: result_o = x_i;
        endcase
    end

endmodule

// File: rtl/vscpu_gen2.sv
// Multi-cycle memory-to-memory CPU with a req/ack word-addressed memory port.
// Define VSCPU_GEN2_MUL_EN to include MUL/MULi; otherwise opcode 5 retires as illegal.
module vscpu_gen2
    import vscpu_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 14,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          halted,
    output logic          illegal
);

    localparam int            OP_LSB = op_lsb(DW);
    localparam int            IM_POS = im_pos(DW);
    localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] iw_q, iw_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          illegal_q, illegal_d;

    opcode_e       op, f_op;
    logic          f_im;
    logic [AW-1:0] fa, fb, f_a, f_b;
    logic [AW-1:0] pc_inc, br_tgt;
    logic [DW-1:0] alu_res;

    assign op     = opcode_e'(iw_q[OP_LSB +: 3]);
    assign fa     = iw_q[AW +: AW];
    assign fb     = iw_q[0 +: AW];

    // The instruction word is decoded straight off the bus on the fetch handshake.
    assign f_op   = opcode_e'(mem_rdata[OP_LSB +: 3]);
    assign f_im   = mem_rdata[IM_POS];
    assign f_a    = mem_rdata[AW +: AW];
    assign f_b    = mem_rdata[0 +: AW];

    assign pc_inc = pc_q + AW'(1);
    assign br_tgt = (state_q == ST_RD_A) ? (mem_rdata[AW-1:0] + fb) : fa;

    vscpu_alu #(.DW(DW)) u_alu (
        .op_i     (op),
        .a_i      (mem_rdata),
        .x_i      (x_q),
        .result_o (alu_res)
    );

    // NOTE: state uses non-blocking assignments; rst is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= PC_RST;
            iw_q      <= '0;
            x_q       <= '0;
            wa_q      <= '0;
            wd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            iw_q      <= iw_d;
            x_q       <= x_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        iw_d      = iw_q;
        x_d       = x_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH: if (mem_ack) begin
                iw_d = mem_rdata;
                x_d  = DW'(f_b);
                if (!f_im || op_is_illegal(f_op)) begin
                    state_d = ST_RD_B;
                end else if (f_op == OP_CP) begin
                    wa_d    = f_a;
                    wd_d    = DW'(f_b);
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD_A;
                end
            end
            ST_RD_B: if (mem_ack) begin
                x_d = mem_rdata;
                if (op_is_illegal(op)) begin
                    pc_d      = pc_inc;
                    illegal_d = 1'b1;
                    state_d   = ST_FETCH;
                end else if (op == OP_BZJ) begin
                    if (mem_rdata == '0) begin
                        pc_d    = br_tgt;
                        state_d = (br_tgt == pc_q) ? ST_HALT : ST_FETCH;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                end else if (op == OP_CP) begin
                    wa_d    = fa;
                    wd_d    = mem_rdata;
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD_A;
                end
            end
            ST_RD_A: if (mem_ack) begin
                if (op == OP_BZJ) begin
                    pc_d    = br_tgt;
                    state_d = (br_tgt == pc_q) ? ST_HALT : ST_FETCH;
                end else if (op == OP_CPI) begin
                    wa_d    = mem_rdata[AW-1:0];
                    wd_d    = x_q;
                    state_d = ST_WR;
                end else begin
                    wa_d    = fa;
                    wd_d    = alu_res;
                    state_d = ST_WR;
                end
            end
            ST_WR: if (mem_ack) begin
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Bus signals depend only on registered state, so they hold steady across a stall.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = wd_q;
        case (state_q)
            ST_FETCH: mem_req = 1'b1;
            ST_RD_B: begin
                mem_req  = 1'b1;
                mem_addr = fb;
            end
            ST_RD_A: begin
                mem_req  = 1'b1;
                mem_addr = fa;
            end
            ST_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wa_q;
            end
            default: mem_req = 1'b0;
        endcase
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_vscpu_gen2.sv
// Directed bench for vscpu_gen2: memory model with optional ack stalls and a write scoreboard.
// Expectations under VSCPU_GEN2_MUL_EN follow the same macro as the design.
module tb_vscpu_gen2;

    localparam int DW = 32;
    localparam int AW = 14;

    localparam logic [2:0] T_ADD = 3'd0, T_NAND = 3'd1, T_SRL = 3'd2, T_LT = 3'd3;
    localparam logic [2:0] T_CP  = 3'd4, T_MUL  = 3'd5, T_BZJ = 3'd6, T_CPI = 3'd7;
    localparam logic [AW-1:0] ZERO = 14'd100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req, mem_we, mem_ack = 1'b0, halted, illegal;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct { int c; logic [AW-1:0] a; logic w; } acc_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

    acc_t acc_q[$];
    wr_t  exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ill_cnt = 0;
    int ack_mode = 0;   // 0 immediate, 1 random 0-5 stall, 2 never, 3 never for writes

    vscpu_gen2 #(.DW(DW), .AW(AW), .RESET_PC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .illegal   (illegal)
    );

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (illegal === 1'b1) ill_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: ack decided on the falling edge, access completes on the next rising edge.
    logic          pending = 1'b0;
    int            stall = 0;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [DW-1:0] s_wd;
    acc_t          rec;
    wr_t           ex;
    always @(negedge clk) begin
        if (mem_ack) pending = 1'b0;
        mem_ack = 1'b0;
        if (mem_req !== 1'b1) begin
            pending = 1'b0;
        end else begin
            if (!pending) begin
                pending = 1'b1;
                stall   = (ack_mode == 1) ? int'($urandom_range(0, 5)) : 0;
                s_addr  = mem_addr;
                s_we    = mem_we;
                s_wd    = mem_wdata;
            end else begin
                check("stall_addr", mem_addr, s_addr);
                check("stall_we", mem_we, s_we);
                check("stall_wdata", mem_wdata, s_wd);
            end
            if (!(ack_mode == 2 || (ack_mode == 3 && mem_we))) begin
                if (stall > 0) begin
                    stall--;
                end else begin
                    mem_ack = 1'b1;
                    rec.c = cyc;
                    rec.a = mem_addr;
                    rec.w = mem_we;
                    acc_q.push_back(rec);
                    if (mem_we) begin
                        check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            ex = exp_q.pop_front();
                            check("wr_addr", mem_addr, ex.a);
                            check("wr_data", mem_wdata, ex.d);
                        end
                        mem[mem_addr] = mem_wdata;
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic im,
                                          input logic [AW-1:0] a, input logic [AW-1:0] b);
        return {op, im, a, b};
    endfunction

    function automatic logic [DW-1:0] halt_at(input logic [AW-1:0] p);
        return enc(T_BZJ, 1'b0, p, ZERO);
    endfunction

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        acc_q.delete();
        ill_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("halt_reached", halted, 1'b1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic load_prog3();
        clear_mem();
        mem[0]  = enc(T_ADD,  1'b1, 14'd40, 14'd5);
        mem[1]  = enc(T_NAND, 1'b0, 14'd42, 14'd40);
        mem[2]  = enc(T_SRL,  1'b0, 14'd40, 14'd41);
        mem[3]  = enc(T_LT,   1'b0, 14'd41, 14'd43);
        mem[4]  = enc(T_LT,   1'b1, 14'd43, 14'd2);
        mem[5]  = enc(T_CP,   1'b0, 14'd44, 14'd42);
        mem[6]  = enc(T_CP,   1'b1, 14'd46, 14'h3FFF);
        mem[7]  = enc(T_SRL,  1'b1, 14'd44, 14'd40);
        mem[8]  = enc(T_BZJ,  1'b0, 14'd11, 14'd44);
        mem[9]  = enc(T_CP,   1'b1, 14'd47, 14'd1);
        mem[10] = enc(T_CP,   1'b1, 14'd47, 14'd2);
        mem[11] = enc(T_BZJ,  1'b1, 14'd45, 14'd3);
        mem[12] = enc(T_CP,   1'b1, 14'd47, 14'd3);
        mem[13] = enc(T_NAND, 1'b1, 14'd42, 14'hFF);
        mem[14] = enc(T_ADD,  1'b0, 14'd46, 14'd46);
        mem[15] = halt_at(14'd15);
        mem[40] = 32'd100;
        mem[41] = 32'd3;
        mem[42] = 32'h0000_F0F0;
        mem[43] = 32'd6;
        mem[45] = 32'd10;
        push_exp(14'd40, 32'd105);
        push_exp(14'd42, 32'hFFFF_FF9F);
        push_exp(14'd40, 32'd13);
        push_exp(14'd41, 32'd1);
        push_exp(14'd43, 32'd0);
        push_exp(14'd44, 32'hFFFF_FF9F);
        push_exp(14'd46, 32'h0000_3FFF);
        push_exp(14'd44, 32'd0);
        push_exp(14'd42, 32'hFFFF_FF60);
        push_exp(14'd46, 32'h0000_7FFE);
    endtask

    logic [DW-1:0] exp3 [8];

    initial begin
        int n;
        exp3 = '{32'd13, 32'd1, 32'hFFFF_FF60, 32'd0, 32'd0, 32'd10, 32'h0000_7FFE, 32'd0};
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        repeat (2) @(posedge clk);

        // ADD M[10]+=M[11] with ack high: 4 cycles, then fetch from PC+1
        clear_mem();
        mem[0]  = enc(T_ADD, 1'b0, 14'd10, 14'd11);
        mem[1]  = halt_at(14'd1);
        mem[10] = 32'd5;
        mem[11] = 32'd7;
        push_exp(14'd10, 32'd12);
        ack_mode = 0;
        do_reset();
        run_to_halt(50);
        check("reset_fetch_addr", acc_q[0].a, 14'd0);
        check("reset_fetch_we", acc_q[0].w, 1'b0);
        check("add_rd_b", acc_q[1].a, 14'd11);
        check("add_rd_a", acc_q[2].a, 14'd10);
        check("add_wr_we", acc_q[3].w, 1'b1);
        check("add_next_fetch", acc_q[4].a, 14'd1);
        check("add_cycles", acc_q[4].c - acc_q[0].c, 64'd4);
        check("add_m10", mem[10], 32'd12);

        // CPI / CPIi through a pointer cell
        clear_mem();
        mem[0]  = enc(T_CPI, 1'b0, 14'd20, 14'd21);
        mem[1]  = enc(T_CPI, 1'b1, 14'd20, 14'd3);
        mem[2]  = halt_at(14'd2);
        mem[20] = 32'd30;
        mem[21] = 32'hAB;
        push_exp(14'd30, 32'hAB);
        push_exp(14'd30, 32'd3);
        do_reset();
        run_to_halt(50);
        check("cpi_cycles", acc_q[4].c - acc_q[0].c, 64'd4);
        check("cpii_cycles", acc_q[7].c - acc_q[4].c, 64'd3);
        check("cpi_m30", mem[30], 32'd3);
        check("cpi_m20", mem[20], 32'd30);

        // Mixed program, first with immediate ack, then with random stalls
        for (int run = 0; run < 2; run++) begin
            load_prog3();
            ack_mode = run;
            do_reset();
            run_to_halt(3000);
            for (int i = 0; i < 8; i++) check($sformatf("prog3_run%0d_m%0d", run, 40 + i), mem[40 + i], exp3[i]);
        end
        ack_mode = 0;

        // BZJ not taken (M[5]=1): next fetch is PC+1
        clear_mem();
        mem[0] = enc(T_BZJ, 1'b0, 14'd8, 14'd6);
        mem[8] = enc(T_BZJ, 1'b0, 14'd8, 14'd5);
        mem[9] = halt_at(14'd9);
        mem[5] = 32'd1;
        do_reset();
        run_to_halt(50);
        check("bzj_jump_fetch", acc_q[2].a, 14'd8);
        check("bzj_nt_fetch", acc_q[4].a, 14'd9);
        check("bzj_cycles", acc_q[4].c - acc_q[2].c, 64'd2);

        // BZJ taken to itself (M[5]=0): HALT, no further requests
        mem[5] = 32'd0;
        do_reset();
        run_to_halt(50);
        check("halt_acc_count", 64'(acc_q.size()), 64'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("halt_req_low", mem_req, 1'b0);
        end
        check("halt_acc_after", 64'(acc_q.size()), 64'd4);
        check("halt_held", halted, 1'b1);

        // Reset while a write is stalled: the write is dropped, restart fetches RESET_PC
        clear_mem();
        mem[0]  = enc(T_CP, 1'b1, 14'd50, 14'h55);
        mem[1]  = halt_at(14'd1);
        mem[50] = 32'h11;
        ack_mode = 3;
        do_reset();
        n = 0;
        while (mem_we !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midwr_reached", mem_we, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midwr_rst_req", mem_req, 1'b0);
        check("midwr_rst_we", mem_we, 1'b0);
        @(posedge clk);
        #1;
        check("midwr_no_write", mem[50], 32'h11);
        ack_mode = 0;
        acc_q.delete();
        push_exp(14'd50, 32'h55);
        rst = 1'b0;
        run_to_halt(50);
        check("midwr_refetch_addr", acc_q[0].a, 14'd0);
        check("midwr_refetch_we", acc_q[0].w, 1'b0);

        // MULi M[60]=6 * 7
        clear_mem();
        mem[0]  = enc(T_MUL, 1'b1, 14'd60, 14'd7);
        mem[1]  = halt_at(14'd1);
        mem[60] = 32'd6;
`ifdef VSCPU_GEN2_MUL_EN
        push_exp(14'd60, 32'd42);
        do_reset();
        run_to_halt(50);
        check("muli_m60", mem[60], 32'd42);
        check("muli_next_fetch", acc_q[3].a, 14'd1);
        check("muli_cycles", acc_q[3].c - acc_q[0].c, 64'd3);
        check("muli_no_illegal", 64'(ill_cnt), 64'd0);
`else
        do_reset();
        run_to_halt(50);
        check("ill_m60", mem[60], 32'd6);
        check("ill_next_fetch", acc_q[2].a, 14'd1);
        check("ill_cycles", acc_q[2].c - acc_q[0].c, 64'd2);
        check("ill_pulse", 64'(ill_cnt), 64'd1);
`endif
        check("illegal_low_end", illegal, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
